// File: rtl/shifter_pkg.sv
// Shared definitions for the pipelined log-shifter.
//   - op codes (the two LSBs line up with the legacy SLLI/SRLI/SRAI encoding)
//   - level_first/level_last: which mux levels a given pipeline stage owns
package shifter_pkg;

   localparam logic [2:0] OP_SLL = 3'b000;
   localparam logic [2:0] OP_SRL = 3'b001;
   localparam logic [2:0] OP_SRA = 3'b010;
   localparam logic [2:0] OP_ROL = 3'b011;
   localparam logic [2:0] OP_ROR = 3'b100;
   // 3'b101..3'b111 pass the operand through unchanged

   // Levels are spread as evenly as possible; with stages <= shw every
   // stage owns at least one level.
   function automatic int level_first(input int stage, input int shw, input int stages);
      return (stage * shw) / stages;
   endfunction

   function automatic int level_last(input int stage, input int shw, input int stages);
      return ((stage + 1) * shw) / stages - 1;
   endfunction

endpackage

// File: rtl/shift_level.sv
// One combinational level of the log-shifter: shifts/rotates by 2^LEVEL
// when en is set, otherwise passes data through.
//   data   : operand entering this level
//   en     : shamt bit for this level
//   op     : operation code (shifter_pkg OP_*)
//   sign   : original operand MSB, used as SRA fill
//   result : operand leaving this level
module shift_level
   import shifter_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int LEVEL = 0
) (
   input  logic [WIDTH-1:0] data,
   input  logic             en,
   input  logic [2:0]       op,
   input  logic             sign,
   output logic [WIDTH-1:0] result
);

   localparam int AMT = 1 << LEVEL;

   always_comb begin
      result = data;
      if (en) begin
         case (op)
            OP_SLL:  result = {data[WIDTH-AMT-1:0], {AMT{1'b0}}};
            OP_SRL:  result = {{AMT{1'b0}}, data[WIDTH-1:AMT]};
            OP_SRA:  result = {{AMT{sign}}, data[WIDTH-1:AMT]};
            OP_ROL:  result = {data[WIDTH-AMT-1:0], data[WIDTH-1:WIDTH-AMT]};
            OP_ROR:  result = {data[AMT-1:0], data[WIDTH-1:AMT]};
            default: result = data;
         endcase
      end
   end

endmodule

// File: rtl/pipelined_shifter.sv
// Pipelined shift/rotate unit with valid/ready flow control.
// log2(WIDTH) mux levels are split across PIPE_STAGES register stages;
// latency equals PIPE_STAGES, throughput one result per cycle.
//   clk, rst            : clock, async active-high reset
//   in_valid/in_ready   : request handshake
//   in_data/in_shamt    : operand and unsigned shift amount
//   in_op               : SLL/SRL/SRA/ROL/ROR, others pass through
//   in_tag              : sideband returned with the result
//   out_valid/out_ready : result handshake
//   out_data/out_tag    : result and its tag
module pipelined_shifter
   import shifter_pkg::*;
#(
   parameter int WIDTH       = 32,
   parameter int PIPE_STAGES = 2,
   parameter int TAG_W       = 5
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [WIDTH-1:0]         in_data,
   input  logic [$clog2(WIDTH)-1:0] in_shamt,
   input  logic [2:0]               in_op,
   input  logic [TAG_W-1:0]         in_tag,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [WIDTH-1:0]         out_data,
   output logic [TAG_W-1:0]         out_tag
);

   localparam int SHW = $clog2(WIDTH);

   if ((WIDTH < 8) || (WIDTH > 64) || ((1 << SHW) != WIDTH)) begin : g_bad_width
      $error("pipelined_shifter: WIDTH must be a power of two in 8..64");
   end
   if ((PIPE_STAGES < 1) || (PIPE_STAGES > SHW)) begin : g_bad_stages
      $error("pipelined_shifter: PIPE_STAGES must be in 1..log2(WIDTH)");
   end

   // Control that travels with each entry; the sign bit is captured once
   // at entry so SRA fill does not depend on intermediate data.
   typedef struct packed {
      logic [SHW-1:0] shamt;
      logic [2:0]     op;
      logic           sign;
   } ctl_t;

   logic [PIPE_STAGES-1:0] vld_pipe;
   logic [PIPE_STAGES:0]   ld;
   logic [WIDTH-1:0]       data_q  [PIPE_STAGES];
   logic [TAG_W-1:0]       tag_q   [PIPE_STAGES];
   ctl_t                   ctl_src [PIPE_STAGES];

   // Load-enable ripples back from the consumer: a stage may load when it
   // is empty or its downstream neighbour is loading this cycle.
   always_comb begin
      ld = '0;
      ld[PIPE_STAGES] = out_ready;
      for (int s = PIPE_STAGES - 1; s >= 0; s--)
         ld[s] = !vld_pipe[s] || ld[s+1];
   end

   for (genvar s = 0; s < PIPE_STAGES; s++) begin : g_stage
      localparam int LO = level_first(s, SHW, PIPE_STAGES);
      localparam int HI = level_last(s, SHW, PIPE_STAGES);
      localparam int NL = HI - LO + 1;

      logic [WIDTH-1:0] src_data;
      logic [TAG_W-1:0] src_tag;
      logic             src_vld;
      logic [WIDTH-1:0] lvl [NL+1];

      if (s == 0) begin : g_head
         assign src_data   = in_data;
         assign src_tag    = in_tag;
         assign src_vld    = in_valid;
         assign ctl_src[0] = {in_shamt, in_op, in_data[WIDTH-1]};
      end else begin : g_body
         assign src_data = data_q[s-1];
         assign src_tag  = tag_q[s-1];
         assign src_vld  = vld_pipe[s-1];
      end

      assign lvl[0] = src_data;
      for (genvar l = 0; l < NL; l++) begin : g_lvl
         shift_level #(
            .WIDTH (WIDTH),
            .LEVEL (LO + l)
         ) u_lvl (
            .data   (lvl[l]),
            .en     (ctl_src[s].shamt[LO+l]),
            .op     (ctl_src[s].op),
            .sign   (ctl_src[s].sign),
            .result (lvl[l+1])
         );
      end

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            vld_pipe[s] <= 1'b0;
            data_q[s]   <= '0;
            tag_q[s]    <= '0;
         end else if (ld[s]) begin
            vld_pipe[s] <= src_vld;
            data_q[s]   <= lvl[NL];
            tag_q[s]    <= src_tag;
         end
      end

      // The last stage has no consumer for op/shamt/sign, so only inner
      // boundaries carry control forward.
      if (s < PIPE_STAGES - 1) begin : g_ctl
         ctl_t ctl_q;
         always_ff @(posedge clk or posedge rst) begin
            if (rst)        ctl_q <= '0;
            else if (ld[s]) ctl_q <= ctl_src[s];
         end
         assign ctl_src[s+1] = ctl_q;
      end
   end

   assign in_ready  = ld[0];
   assign out_valid = vld_pipe[PIPE_STAGES-1];
   assign out_data  = data_q[PIPE_STAGES-1];
   assign out_tag   = tag_q[PIPE_STAGES-1];

endmodule

// File: tb/tb_pipelined_shifter.sv
// Bench for pipelined_shifter: three configurations (32/2, 16/4, 64/1)
// share stimulus; a scoreboard fed by an arithmetic reference model checks
// every result, its tag, its latency and output stability under stall.
module tb_pipelined_shifter;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        in_valid;
   logic [63:0] in_data;
   logic [5:0]  in_shamt;
   logic [2:0]  in_op;
   logic [4:0]  in_tag;
   logic        out_ready;
   logic [1:0]  sel;

   logic        in_ready, out_valid;
   logic [63:0] out_data;
   logic [4:0]  out_tag;

   logic [2:0]  iv, ir, ov;
   logic [4:0]  ot [3];
   logic [31:0] od32;
   logic [15:0] od16;
   logic [63:0] od64;

   int cyc = 0;
   int n_chk = 0;
   int n_fail = 0;
   int cur_w, cur_p;
   bit lat_chk;

   typedef struct {
      logic [63:0] d;
      logic [4:0]  tag;
      int          acc;
   } exp_t;
   exp_t sb [$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   for (genvar k = 0; k < 3; k++) begin : g_iv
      assign iv[k] = in_valid && (sel == 2'(k));
   end

   pipelined_shifter #(.WIDTH(32), .PIPE_STAGES(2), .TAG_W(5)) u_dut32 (
      .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]),
      .in_data(in_data[31:0]), .in_shamt(in_shamt[4:0]), .in_op(in_op), .in_tag(in_tag),
      .out_valid(ov[0]), .out_ready(out_ready), .out_data(od32), .out_tag(ot[0]));

   pipelined_shifter #(.WIDTH(16), .PIPE_STAGES(4), .TAG_W(5)) u_dut16 (
      .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]),
      .in_data(in_data[15:0]), .in_shamt(in_shamt[3:0]), .in_op(in_op), .in_tag(in_tag),
      .out_valid(ov[1]), .out_ready(out_ready), .out_data(od16), .out_tag(ot[1]));

   pipelined_shifter #(.WIDTH(64), .PIPE_STAGES(1), .TAG_W(5)) u_dut64 (
      .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]),
      .in_data(in_data), .in_shamt(in_shamt), .in_op(in_op), .in_tag(in_tag),
      .out_valid(ov[2]), .out_ready(out_ready), .out_data(od64), .out_tag(ot[2]));

   always_comb begin
      in_ready  = ir[0];
      out_valid = ov[0];
      out_data  = {32'd0, od32};
      out_tag   = ot[0];
      case (sel)
         2'd1: begin in_ready = ir[1]; out_valid = ov[1]; out_data = {48'd0, od16}; out_tag = ot[1]; end
         2'd2: begin in_ready = ir[2]; out_valid = ov[2]; out_data = od64;          out_tag = ot[2]; end
         default: ;
      endcase
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Reference: plain arithmetic on a w-bit value held in 64 bits.
   function automatic logic [63:0] ref_shift(input int w, input logic [2:0] op,
                                              input logic [63:0] d, input int shamt);
      logic [63:0] m, x;
      int sh;
      m  = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
      x  = d & m;
      sh = shamt % w;
      case (op)
         3'd0:    return (x << sh) & m;
         3'd1:    return x >> sh;
         3'd2:    return (x >> sh) | (x[w-1] ? (m & ~(m >> sh)) : 64'd0);
         3'd3:    return ((x << sh) | (x >> (w - sh))) & m;
         3'd4:    return ((x >> sh) | (x << (w - sh))) & m;
         default: return x;
      endcase
   endfunction

   // Scoreboard / monitor, sampled on the falling edge.
   initial begin
      bit          hold = 0;
      logic [63:0] hold_d;
      logic [4:0]  hold_t;
      exp_t        e;
      forever begin
         @(negedge clk);
         if (rst) begin
            sb.delete();
            hold = 0;
         end else begin
            if (hold) begin
               chk("hold_valid", 64'(out_valid), 64'd1);
               chk("hold_data", out_data, hold_d);
               chk("hold_tag", 64'(out_tag), 64'(hold_t));
            end
            if (out_valid && out_ready) begin
               if (sb.size() == 0) chk("spurious_out", 64'(sb.size()), 64'd1);
               else begin
                  e = sb.pop_front();
                  chk("result_data", out_data, e.d);
                  chk("result_tag", 64'(out_tag), 64'(e.tag));
                  if (lat_chk) chk("latency", 64'(cyc - e.acc), 64'(cur_p));
               end
            end
            hold   = out_valid && !out_ready;
            hold_d = out_data;
            hold_t = out_tag;
            if (in_valid && in_ready) begin
               e.d   = ref_shift(cur_w, in_op, in_data, int'(in_shamt));
               e.tag = in_tag;
               e.acc = cyc;
               sb.push_back(e);
            end
         end
      end
   end

   // Called at posedge+1; returns at posedge+1 after the accepting edge.
   task automatic send(input logic [2:0] op, input logic [63:0] d,
                       input logic [5:0] sh, input logic [4:0] tg);
      bit acc = 0;
      in_valid = 1'b1; in_op = op; in_data = d; in_shamt = sh; in_tag = tg;
      for (int n = 0; n < 300 && !acc; n++) begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk);
         #1;
      end
      if (!acc) chk("send_timeout", 64'(acc), 64'd1);
   endtask

   task automatic drain();
      for (int i = 0; i < 300 && sb.size() != 0; i++) @(negedge clk);
      chk("drain", 64'(sb.size()), 64'd0);
      @(posedge clk);
      #1;
   endtask

   task automatic dir(input string tag, input logic [2:0] op, input logic [63:0] d,
                      input logic [5:0] sh, input logic [4:0] tg, input logic [63:0] exp);
      bit seen = 0;
      send(op, d, sh, tg);
      in_valid = 1'b0;
      for (int i = 0; i < 50 && !seen; i++) begin
         @(negedge clk);
         seen = out_valid;
      end
      chk({tag, "_valid"}, 64'(seen), 64'd1);
      chk(tag, out_data, exp);
      chk({tag, "_tag"}, 64'(out_tag), 64'(tg));
      @(posedge clk);
      #1;
   endtask

   task automatic run_stream(input int n, input bit stall);
      if (stall) lat_chk = 0;
      fork
         begin
            for (int i = 0; i < n; i++)
               send(3'($urandom_range(0, 7)), {$urandom, $urandom},
                    6'($urandom_range(0, cur_w - 1)), 5'($urandom_range(0, 31)));
            in_valid = 1'b0;
         end
         begin
            if (stall) begin
               repeat (3) @(posedge clk);
               #1 out_ready = 1'b0;
               repeat (4) @(posedge clk);
               @(negedge clk);
               chk("in_ready_full", 64'(in_ready), 64'd0);
               chk("stall_out_valid", 64'(out_valid), 64'd1);
               @(posedge clk);
               #1 out_ready = 1'b1;
            end
         end
      join
      drain();
      lat_chk = 1;
   endtask

   task automatic set_cfg(input logic [1:0] s, input int w, input int p);
      sel = s; cur_w = w; cur_p = p;
      @(posedge clk);
      #1;
   endtask

   initial begin
      in_valid = 0; in_data = '0; in_shamt = '0; in_op = '0; in_tag = '0;
      out_ready = 1'b1; sel = 2'd0; cur_w = 32; cur_p = 2; lat_chk = 1;

      #2 rst = 1'b1;
      #1;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_data", out_data, 64'd0);
      chk("rst_out_tag", 64'(out_tag), 64'd0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      chk("in_ready_after_rst", 64'(in_ready), 64'd1);

      // 32-bit, 2 stages
      dir("sll31", 3'd0, 64'h0000_0001, 6'd31, 5'd7, 64'h8000_0000);
      dir("sra4",  3'd2, 64'h8000_0000, 6'd4,  5'd1, 64'hF800_0000);
      dir("srl4",  3'd1, 64'h8000_0000, 6'd4,  5'd2, 64'h0800_0000);
      dir("ror1",  3'd4, 64'h0000_0001, 6'd1,  5'd3, 64'h8000_0000);
      dir("rol4",  3'd3, 64'h8000_0001, 6'd4,  5'd4, 64'h0000_0018);
      for (int op = 0; op < 8; op++) begin
         logic [63:0] d;
         d = {32'd0, $urandom};
         dir("shamt0", 3'(op), d, 6'd0, 5'(op), d);
      end
      for (int i = 0; i < 3; i++) begin
         logic [63:0] d;
         d = {32'd0, $urandom};
         dir("pass111", 3'b111, d, 6'($urandom_range(1, 31)), 5'(i), d);
      end
      run_stream(10, 1'b1);
      run_stream(30, 1'b0);

      // Reset with two entries in flight
      out_ready = 1'b0;
      send(3'd0, 64'h0000_00FF, 6'd4, 5'd9);
      send(3'd1, 64'hF000_0000, 6'd8, 5'd10);
      in_valid = 1'b0;
      chk("pre_rst_valid", 64'(out_valid), 64'd1);
      #1 rst = 1'b1;
      #1;
      chk("midrst_out_valid", 64'(out_valid), 64'd0);
      chk("midrst_out_data", out_data, 64'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      out_ready = 1'b1;
      chk("in_ready_after_midrst", 64'(in_ready), 64'd1);
      dir("post_rst", 3'd3, 64'h1234_5678, 6'd8, 5'd21, 64'h3456_7812);
      drain();

      // 16-bit, 4 stages
      set_cfg(2'd1, 16, 4);
      dir("sra15_w16", 3'd2, 64'h8000, 6'd15, 5'd5, 64'hFFFF);
      run_stream(10, 1'b1);
      run_stream(20, 1'b0);

      // 64-bit, 1 stage
      set_cfg(2'd2, 64, 1);
      dir("ror63_w64", 3'd4, 64'h1, 6'd63, 5'd6, 64'h2);
      dir("sll63_w64", 3'd0, 64'h1, 6'd63, 5'd8, 64'h8000_0000_0000_0000);
      run_stream(10, 1'b1);
      run_stream(20, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete, %0d failures so far", n_fail);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/pipelined_shifter.md
Name: pipelined_shifter

Overview:
- Parametrised, pipelined successor to the 32-bit combinational shifter used by the RV32 execute stage.
- Generalised data width and pipeline depth; adds rotate modes, a transaction tag and valid/ready flow control with full-throughput stalls.
- Sits between the ALU operand mux and the writeback arbiter; also reusable by the future bit-manipulation (Zbb) unit.

Parameters:
- WIDTH, 32, data width in bits; power of two, 8..64.
- PIPE_STAGES, 2, number of registered stages, 1..log2(WIDTH); equals the latency in cycles.
- TAG_W, 5, width of the sideband tag (e.g. rd index) carried alongside the data.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  request valid.
- in_ready  output  1  stage 0 can accept this cycle.
- in_data  input  WIDTH  operand.
- in_shamt  input  log2(WIDTH)  shift amount; unsigned, full range legal.
- in_op  input  3  000 SLL, 001 SRL, 010 SRA, 011 ROL, 100 ROR, 101..111 pass-through. The two LSBs match the legacy SLLI/SRLI/SRAI encoding.
- in_tag  input  TAG_W  opaque sideband, returned unchanged.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- out_data  output  WIDTH  result.
- out_tag  output  TAG_W  tag of the result.

Behaviour:
- Log-shifter with SHW = log2(WIDTH) mux levels. Level i conditionally shifts or rotates by 2^i, controlled by shamt[i].
- Stage s (0..PIPE_STAGES-1) implements levels floor(s*SHW/P) .. floor((s+1)*SHW/P)-1, then registers data, remaining shamt bits, op, tag and a valid bit v[s].
- Fill rules:
  - SLL: fills zeros at the LSB.
  - SRL: fills zeros at the MSB.
  - SRA: fills the original operand sign bit, carried through the pipeline with the op.
  - ROL/ROR: wrap the bits around.
  - Pass-through: data unchanged at every level.
- Flow control:
  - adv[P] = out_ready.
  - Stage s loads when !v[s] || adv[s+1].
  - in_ready = !v[0] || adv[1].
  - A transfer occurs on in_valid && in_ready. Any stage whose upstream has no valid entry clears its valid bit on load.
  - out_valid = v[P-1]. out_data and out_tag hold stable while out_valid && !out_ready.
- Throughput: one result per cycle when out_ready is held high. Latency is exactly PIPE_STAGES cycles from accept to out_valid.
- Backpressure: when out_ready is low, the pipeline fills. With all v[] set, in_ready drops in the same cycle (combinational path from out_ready). No entry is lost or duplicated.
- Simultaneous accept on input and output when full: both transfer, occupancy unchanged.
- in_ready may depend combinationally on out_ready. out_valid must not depend combinationally on in_valid.
- shamt = 0: output equals input for every op.
- Reset (asynchronous, mid-operation allowed): all v[] = 0, out_valid = 0, out_data = 0, out_tag = 0, all pipeline registers = 0. In-flight entries are discarded. in_ready = 1 in the first cycle after reset is released.
- Illegal parameter values (non-power-of-two WIDTH, PIPE_STAGES > SHW) trigger an elaboration-time error.

Decomposition:
- shifter_pkg:
  - op codes OP_SLL, OP_SRL, OP_SRA, OP_ROL, OP_ROR.
  - level-range function that returns the first and last level per stage.
- Sub-module shift_level (combinational, one mux level; parameters WIDTH and LEVEL; inputs data, enable bit, op, sign; output data). It is instantiated SHW times via generate, with pipeline registers inserted at the stage boundaries in pipelined_shifter.

Test Plan:
- SLL 0x00000001, shamt 31, tag 7, out_ready=1 -> 0x80000000 and tag 7 exactly 2 cycles after accept.
- SRA 0x80000000 shamt 4 -> 0xF8000000. SRL with the same operand and shamt -> 0x08000000. ROR 0x00000001 shamt 1 -> 0x80000000. ROL 0x80000001 shamt 4 -> 0x00000018.
- Back-to-back stream of 10 random ops, with out_ready low for cycles 3-7:
  - in_ready falls once the pipeline is full.
  - All 10 results match the reference model, in order, with no drop or duplicate.
  - out_data stays stable during the stall.
- Assert rst while 2 entries are in flight -> out_valid=0 and out_data=0 immediately. After release, a new accept produces only the new result.
- shamt 0 for every op, plus op 111 with any shamt -> out_data equals in_data.
- Re-run the random test with WIDTH=16 and PIPE_STAGES=4, then WIDTH=64 and PIPE_STAGES=1:
  - latency equals PIPE_STAGES in each configuration.
  - SRA 0x8000 shamt 15 -> 0xFFFF in the 16-bit configuration.
